// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// mem_bus_arbiter_if : instruction, data and memory bus signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_readdata;
  logic        i_waitrequest;

  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_readdata;
  logic        d_waitrequest;

  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;

  // Arbiter side
  modport slave (
    input  i_read, i_address,
    output i_readdata, i_waitrequest,
    input  d_read, d_write, d_address, d_writedata, d_byteenable,
    output d_readdata, d_waitrequest,
    output m_address, m_read, m_write, m_writedata, m_byteenable,
    input  m_waitrequest, m_readdata
  );

  // Requesters and memory side
  modport master (
    output i_read, i_address,
    input  i_readdata, i_waitrequest,
    output d_read, d_write, d_address, d_writedata, d_byteenable,
    input  d_readdata, d_waitrequest,
    input  m_address, m_read, m_write, m_writedata, m_byteenable,
    output m_waitrequest, m_readdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : two-port (fetch/data) to single memory bus arbiter.
// Tie policy: data-first by default, round-robin with ARB_ROUND_ROBIN_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter (
  input wire logic          clk,
  input wire logic          reset,
  mem_bus_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUS_I   = 3'd1,
    BUS_D   = 3'd2,
    RDATA_I = 3'd3,
    RDATA_D = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wr_q, wr_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic i_req, d_req, grant_d, i_done, d_done, in_bus;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = instruction port won last, 1 = data port won last
  logic last_grant_q, last_grant_d;
`endif

  always_comb begin
    i_req = bus.i_read;
    d_req = bus.d_read | bus.d_write;
`ifdef ARB_ROUND_ROBIN_EN
    grant_d      = d_req & (~i_req | ~last_grant_q);
    last_grant_d = last_grant_q;
`else
    grant_d      = d_req;
`endif
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    wr_d      = wr_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done    = 1'b0;
    d_done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          addr_d  = bus.d_address;
          wdata_d = bus.d_writedata;
          be_d    = bus.d_byteenable;
          wr_d    = bus.d_write;
          state_d = BUS_D;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = 1'b1;
`endif
        end else if (i_req) begin
          addr_d  = bus.i_address;
          wdata_d = 32'h0;
          be_d    = 4'b1111;
          wr_d    = 1'b0;
          state_d = BUS_I;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = 1'b0;
`endif
        end
      end
      BUS_I, BUS_D: begin
        if (!bus.m_waitrequest) begin
          if (wr_q) begin
            state_d = IDLE;
            if (state_q == BUS_D) d_done = 1'b1;
            else                  i_done = 1'b1;
          end else if (state_q == BUS_D) begin
            state_d = RDATA_D;
          end else begin
            state_d = RDATA_I;
          end
        end
      end
      RDATA_I: begin
        i_done  = 1'b1;
        state_d = IDLE;
        // A withdrawn requester gets no data; its last result is kept
        if (i_req) i_rdata_d = bus.m_readdata;
      end
      RDATA_D: begin
        d_done  = 1'b1;
        state_d = IDLE;
        if (d_req) d_rdata_d = bus.m_readdata;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      wr_q      <= 1'b0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      wr_q      <= wr_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign in_bus = (state_q == BUS_I) || (state_q == BUS_D);

  assign bus.m_address    = addr_q;
  assign bus.m_writedata  = wdata_q;
  assign bus.m_byteenable = be_q;
  assign bus.m_read       = in_bus & ~wr_q;
  assign bus.m_write      = in_bus &  wr_q;

  // While reset is held every requester is stalled
  assign bus.i_waitrequest = i_req & ~(reset & i_done);
  assign bus.d_waitrequest = d_req & ~(reset & d_done);

  assign bus.i_readdata = (state_q == RDATA_I && i_req) ? bus.m_readdata : i_rdata_q;
  assign bus.d_readdata = (state_q == RDATA_D && d_req) ? bus.m_readdata : d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter : directed self-checking bench for mem_bus_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic clear_reqs();
    bus.i_read  = 1'b0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
  endtask

  logic [31:0] win_addr;
  logic        win_is_d;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    clear_reqs();
    bus.i_address     = 32'h0;
    bus.d_address     = 32'h0;
    bus.d_writedata   = 32'h0;
    bus.d_byteenable  = 4'h0;
    bus.m_waitrequest = 1'b0;
    bus.m_readdata    = 32'h0;

    // Reset state
    tick();
    tick();
    sample();
    check("rst_m_read", {31'h0, bus.m_read}, 32'h0);
    check("rst_m_write", {31'h0, bus.m_write}, 32'h0);
    check("rst_m_address", bus.m_address, 32'h0);
    check("rst_i_readdata", bus.i_readdata, 32'h0);
    check("rst_d_readdata", bus.d_readdata, 32'h0);
    tick();
    reset = 1'b1;

    // Lone fetch: completes in the third cycle
    bus.i_read     = 1'b1;
    bus.i_address  = 32'hBFC00000;
    bus.m_readdata = 32'h3C08BFC0;
    sample();
    check("fetch_c0_wait", {31'h0, bus.i_waitrequest}, 32'h1);
    check("fetch_c0_m_read", {31'h0, bus.m_read}, 32'h0);
    tick(); sample();
    check("fetch_c1_m_read", {31'h0, bus.m_read}, 32'h1);
    check("fetch_c1_addr", bus.m_address, 32'hBFC00000);
    check("fetch_c1_wait", {31'h0, bus.i_waitrequest}, 32'h1);
    tick(); sample();
    check("fetch_c2_wait", {31'h0, bus.i_waitrequest}, 32'h0);
    check("fetch_c2_rdata", bus.i_readdata, 32'h3C08BFC0);
    check("fetch_c2_m_read", {31'h0, bus.m_read}, 32'h0);
    tick();
    bus.i_read     = 1'b0;
    bus.m_readdata = 32'h12345678;
    sample();
    check("fetch_hold_rdata", bus.i_readdata, 32'h3C08BFC0);

    // Data write: completes in the second cycle
    tick();
    bus.d_write      = 1'b1;
    bus.d_address    = 32'hBFC00030;
    bus.d_writedata  = 32'hDEADBEEF;
    bus.d_byteenable = 4'b1111;
    sample();
    check("wr_c0_wait", {31'h0, bus.d_waitrequest}, 32'h1);
    check("wr_c0_m_write", {31'h0, bus.m_write}, 32'h0);
    tick(); sample();
    check("wr_c1_m_write", {31'h0, bus.m_write}, 32'h1);
    check("wr_c1_m_read", {31'h0, bus.m_read}, 32'h0);
    check("wr_c1_addr", bus.m_address, 32'hBFC00030);
    check("wr_c1_data", bus.m_writedata, 32'hDEADBEEF);
    check("wr_c1_be", {28'h0, bus.m_byteenable}, 32'hF);
    check("wr_c1_wait", {31'h0, bus.d_waitrequest}, 32'h0);
    tick();
    bus.d_write = 1'b0;
    sample();
    check("wr_c2_m_write", {31'h0, bus.m_write}, 32'h0);

    // Read and write together is a write
    tick();
    bus.d_read      = 1'b1;
    bus.d_write     = 1'b1;
    bus.d_address   = 32'h00000040;
    bus.d_writedata = 32'h0BADF00D;
    tick(); sample();
    check("rw_m_write", {31'h0, bus.m_write}, 32'h1);
    check("rw_m_read", {31'h0, bus.m_read}, 32'h0);
    tick();
    clear_reqs();

    // Memory stall on a data read
    tick();
    bus.d_read        = 1'b1;
    bus.d_address     = 32'h00000100;
    bus.m_waitrequest = 1'b1;
    bus.m_readdata    = 32'h0000000A;
    for (int k = 0; k < 5; k++) begin
      tick(); sample();
      check("stall_m_read", {31'h0, bus.m_read}, 32'h1);
      check("stall_addr", bus.m_address, 32'h00000100);
      check("stall_wait", {31'h0, bus.d_waitrequest}, 32'h1);
    end
    tick();
    bus.m_waitrequest = 1'b0;
    sample();
    check("stall_acc_wait", {31'h0, bus.d_waitrequest}, 32'h1);
    tick(); sample();
    check("stall_rdata", bus.d_readdata, 32'h0000000A);
    check("stall_done_wait", {31'h0, bus.d_waitrequest}, 32'h0);
    check("stall_rdata_m_read", {31'h0, bus.m_read}, 32'h0);
    tick();
    clear_reqs();

    // Reset in the middle of a fetch
    tick();
    bus.i_read        = 1'b1;
    bus.i_address     = 32'h00000080;
    bus.m_waitrequest = 1'b1;
    tick();
    reset            = 1'b0;
    bus.d_write      = 1'b1;
    bus.d_address    = 32'h00000200;
    bus.d_writedata  = 32'h00000055;
    bus.d_byteenable = 4'b0011;
    sample();
    check("mrst_busi_m_read", {31'h0, bus.m_read}, 32'h1);
    check("mrst_i_wait", {31'h0, bus.i_waitrequest}, 32'h1);
    check("mrst_d_wait", {31'h0, bus.d_waitrequest}, 32'h1);
    tick();
    reset             = 1'b1;
    bus.m_waitrequest = 1'b0;
    sample();
    check("mrst_m_read", {31'h0, bus.m_read}, 32'h0);
    check("mrst_i_rdata", bus.i_readdata, 32'h0);
    check("mrst_d_rdata", bus.d_readdata, 32'h0);
    tick(); sample();
    check("mrst_grant_m_write", {31'h0, bus.m_write}, 32'h1);
    check("mrst_grant_addr", bus.m_address, 32'h00000200);
    check("mrst_grant_be", {28'h0, bus.m_byteenable}, 32'h3);
    tick();
    clear_reqs();

    // Tie between fetch and data read over four transfers
    tick();
    apply_reset();
    bus.i_read     = 1'b1;
    bus.i_address  = 32'h00001000;
    bus.d_read     = 1'b1;
    bus.d_address  = 32'h00002000;
    bus.m_readdata = 32'hCAFE0000;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_is_d = (k % 2 == 0);
`else
      win_is_d = 1'b1;
`endif
      win_addr = win_is_d ? 32'h00002000 : 32'h00001000;
      sample();
      check("tie_idle_m_read", {31'h0, bus.m_read}, 32'h0);
      tick(); sample();
      check("tie_grant_addr", bus.m_address, win_addr);
      tick(); sample();
      check("tie_d_wait", {31'h0, bus.d_waitrequest}, {31'h0, ~win_is_d});
      check("tie_i_wait", {31'h0, bus.i_waitrequest}, {31'h0, win_is_d});
      tick();
    end
    clear_reqs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
